// File: rtl/axis_i2c_arbiter.sv
// axis_i2c_arbiter: round-robin arbiter sharing one I2C engine between NUM_REQ AXIS command sources.
// Latency: s_tvalid -> m_tvalid 1 cycle; grant held until the engine drops i2c_busy, then GAP_CYCLES idle.
// Backpressure: only the owner sees s_tready (= m_tready) while sending; all other requesters stall.
// Optional watchdog on the engine wait states: define I2C_ARB_TIMEOUT_EN.
module axis_i2c_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          arstn,
  input  logic [NUM_REQ-1:0]            s_tvalid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] s_tdata,
  output logic [NUM_REQ-1:0]            s_tready,
  output logic                          m_tvalid,
  output logic [DATA_WIDTH-1:0]         m_tdata,
  input  logic                          m_tready,
  input  logic                          i2c_busy,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            done,
  output logic                          timeout
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT_BUSY, S_WAIT_DONE, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic            owned_q, owned_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [NUM_REQ-1:0] owner_oh;
  logic [IW-1:0]   rr_idx;
  logic            rr_found;
  logic [IW-1:0]   cand_idx;
  int              cand;
  logic            tmo_hit;

  // One-hot view of the current owner; all zero while nobody holds the engine
  always_comb begin
    owner_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      owner_oh[i] = owned_q && (gidx_q == IW'(i));
    end
  end

  assign grant = owner_oh;

  // Round-robin pick: first valid requester after the last one served, wrapping around
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = ptr_q;
    cand     = 0;
    cand_idx = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IW'(cand);
      if (!rr_found && s_tvalid[cand_idx]) begin
        rr_found = 1'b1;
        rr_idx   = cand_idx;
      end
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_q;

  // Watchdog: counts cycles spent waiting on the engine, restarting on every state change
  always_ff @(posedge clk) begin
    if (!arstn || (state_d != state_q)) tmo_cnt_q <= '0;
    else if (state_q == S_WAIT_BUSY || state_q == S_WAIT_DONE) tmo_cnt_q <= tmo_cnt_q + 1'b1;
  end

  assign tmo_hit = (state_q == S_WAIT_BUSY || state_q == S_WAIT_DONE) &&
                   (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_tmo_cfg;
  assign tmo_hit        = 1'b0;
  assign unused_tmo_cfg = (TIMEOUT_CYCLES != 0);
`endif

  // Next-state and output decode; one beat per grant, grant held until the bus goes idle
  always_comb begin
    state_d   = state_q;
    gidx_d    = gidx_q;
    ptr_d     = ptr_q;
    owned_d   = owned_q;
    gap_cnt_d = gap_cnt_q;
    m_tvalid  = 1'b0;
    s_tready  = '0;
    done      = '0;
    timeout   = 1'b0;
    m_tdata   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gidx_q == IW'(i)) m_tdata = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
    end

    case (state_q)
      S_IDLE: begin
        if (rr_found) begin
          gidx_d  = rr_idx;
          owned_d = 1'b1;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        m_tvalid = s_tvalid[gidx_q];
        s_tready = owner_oh & {NUM_REQ{m_tready}};
        if (!s_tvalid[gidx_q]) begin
          // Requester withdrew before the handshake: release without touching the rotation
          owned_d = 1'b0;
          state_d = S_IDLE;
        end else if (m_tready) begin
          state_d = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (i2c_busy) begin
          state_d = S_WAIT_DONE;
        end else if (tmo_hit) begin
          timeout   = 1'b1;
          owned_d   = 1'b0;
          ptr_d     = gidx_q;
          gap_cnt_d = '0;
          state_d   = S_GAP;
        end
      end
      S_WAIT_DONE: begin
        if (!i2c_busy) begin
          done      = owner_oh;
          owned_d   = 1'b0;
          ptr_d     = gidx_q;
          gap_cnt_d = '0;
          state_d   = S_GAP;
        end else if (tmo_hit) begin
          timeout   = 1'b1;
          owned_d   = 1'b0;
          ptr_d     = gidx_q;
          gap_cnt_d = '0;
          state_d   = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GW'(GAP_CYCLES - 1)) state_d = S_IDLE;
        else gap_cnt_d = gap_cnt_q + 1'b1;
      end
      default: begin
        owned_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    // A reset cycle never reports a completed or abandoned transfer
    if (!arstn) begin
      done    = '0;
      timeout = 1'b0;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!arstn) begin
      state_q   <= S_IDLE;
      gidx_q    <= '0;
      ptr_q     <= IW'(NUM_REQ - 1);
      owned_q   <= 1'b0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gidx_q    <= gidx_d;
      ptr_q     <= ptr_d;
      owned_q   <= owned_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

endmodule

// File: tb/tb_axis_i2c_arbiter.sv
// tb_axis_i2c_arbiter: scenario tasks plus a randomized queue-level round-robin model.
// Inputs change on the falling edge; outputs are sampled 1-3 time units after it.
// A small engine model raises i2c_busy after each accepted beat unless a test drives it by hand.
module tb_axis_i2c_arbiter;
  localparam int NR = 4, DW = 16, GAP = 4, TMO = 8;

  logic clk = 1'b0;
  logic arstn;
  logic [NR-1:0] s_tvalid, s_tready, grant, done;
  logic [NR*DW-1:0] s_tdata;
  logic m_tvalid, m_tready, i2c_busy, timeout;
  logic [DW-1:0] m_tdata;

  int total = 0, bad = 0;
  logic eng_auto = 1'b1, eng_busy = 1'b0, man_busy = 1'b0;
  int eng_len = 5, eng_cnt = 0;
  int viol_cnt = 0, tmo_n = 0, zero_run = 0;
  int gnt_q[$], gap_q[$], done_q[$], hs_req_q[$];
  logic [DW-1:0] hs_dat_q[$], m_dat_q[$];
  logic [NR-1:0] prev_grant = '0;

  axis_i2c_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .arstn(arstn), .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tready(s_tready),
    .m_tvalid(m_tvalid), .m_tdata(m_tdata), .m_tready(m_tready), .i2c_busy(i2c_busy),
    .grant(grant), .done(done), .timeout(timeout));

  always #5 clk = ~clk;
  assign i2c_busy = eng_auto ? eng_busy : man_busy;

  function automatic int oh2idx(input logic [NR-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NR; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Engine model and event recorder
  always @(negedge clk) begin
    if (eng_cnt > 0) begin
      eng_busy = (eng_cnt <= eng_len);
      eng_cnt--;
    end else eng_busy = 1'b0;
    #2;
    if (m_tvalid && m_tready) begin
      m_dat_q.push_back(m_tdata);
      if (eng_auto) eng_cnt = eng_len + 1;
    end
    for (int i = 0; i < NR; i++)
      if (s_tvalid[i] && s_tready[i]) begin
        hs_req_q.push_back(i);
        hs_dat_q.push_back(s_tdata[i*DW +: DW]);
      end
    if (done != 0) done_q.push_back(oh2idx(done));
    if (timeout === 1'b1) tmo_n++;
    if ($countones(grant) > 1 || $countones(done) > 1 || (s_tready & ~grant) != 0 || (m_tvalid && grant == 0))
      viol_cnt++;
    if (grant != 0 && prev_grant == 0) begin
      gnt_q.push_back(oh2idx(grant));
      gap_q.push_back(zero_run);
    end
    if (grant == 0) zero_run++; else zero_run = 0;
    prev_grant = grant;
  end

  task automatic do_reset();
    s_tvalid = '0; m_tready = 1'b1; man_busy = 1'b0; eng_auto = 1'b1;
    repeat (25) @(negedge clk);
    arstn = 1'b0;
    repeat (2) @(negedge clk);
    arstn = 1'b1;
    gnt_q.delete(); gap_q.delete(); done_q.delete(); hs_req_q.delete(); hs_dat_q.delete(); m_dat_q.delete();
    viol_cnt = 0; tmo_n = 0;
  endtask

  task automatic test_reset();
    @(negedge clk); arstn = 1'b0; s_tvalid = '1; m_tready = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL rst_grant: got %b want 0000", grant); end
    total++; if (done !== 4'b0000) begin bad++; $display("FAIL rst_done: got %b want 0000", done); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL rst_timeout: got %b want 0", timeout); end
    total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL rst_mvalid: got %b want 0", m_tvalid); end
    total++; if (s_tready !== 4'b0000) begin bad++; $display("FAIL rst_sready: got %b want 0000", s_tready); end
    @(negedge clk); arstn = 1'b1;
    @(negedge clk); #1;
    total++; if (grant !== 4'b0001) begin bad++; $display("FAIL rst_first_grant: got %b want 0001", grant); end
    s_tvalid = '0;
  endtask

  task automatic test_single();
    int d_ok, first, n1;
    do_reset(); eng_len = 5;
    @(negedge clk); s_tvalid = 4'b0010; s_tdata[1*DW +: DW] = 16'hA55A; m_tready = 1'b1; #1;
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL single_pre: got %b want 0000", grant); end
    @(negedge clk); #1;
    total++; if (grant !== 4'b0010) begin bad++; $display("FAIL single_grant: got %b want 0010", grant); end
    total++; if (m_tvalid !== 1'b1 || m_tdata !== 16'hA55A) begin bad++; $display("FAIL single_beat: got v=%b d=%h want v=1 d=a55a", m_tvalid, m_tdata); end
    total++; if (s_tready !== 4'b0010) begin bad++; $display("FAIL single_sready: got %b want 0010", s_tready); end
    @(negedge clk); s_tvalid = '0; #1;
    total++; if (s_tready !== 4'b0000 || m_tvalid !== 1'b0) begin bad++; $display("FAIL single_post_hs: got rdy=%b v=%b want 0000/0", s_tready, m_tvalid); end
    d_ok = 0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk); #1;
      if (done != 0) begin d_ok = 1; break; end
    end
    total++; if (d_ok == 0 || done !== 4'b0010) begin bad++; $display("FAIL single_done: got %b want 0010", done); end
    @(negedge clk); s_tvalid = 4'b1000; s_tdata[3*DW +: DW] = 16'h1234; #1;
    total++; if (done !== 4'b0000) begin bad++; $display("FAIL single_done_pulse: got %b want 0000", done); end
    // four gap cycles, then one arbitration cycle before the next beat is offered
    first = -1;
    for (int k = 1; k <= 12; k++) begin
      if (m_tvalid === 1'b1) begin first = k; break; end
      @(negedge clk); #1;
    end
    total++; if (first != GAP + 2) begin bad++; $display("FAIL gap_len: got %0d want %0d", first, GAP + 2); end
    @(negedge clk); s_tvalid = '0;
    n1 = 0;
    foreach (hs_req_q[k]) if (hs_req_q[k] == 1) n1++;
    total++; if (n1 != 1 || hs_dat_q[0] !== 16'hA55A) begin bad++; $display("FAIL single_one_beat: got n=%0d d=%h want 1/a55a", n1, hs_dat_q[0]); end
    repeat (40) @(negedge clk);
  endtask

  task automatic test_round_robin();
    int ok;
    do_reset(); eng_len = 20;
    @(negedge clk);
    for (int i = 0; i < NR; i++) s_tdata[i*DW +: DW] = 16'hC000 + 16'(i);
    s_tvalid = '1;
    ok = 0;
    for (int t = 0; t < 800; t++) begin
      @(negedge clk); #3;
      if (gnt_q.size() >= 5) begin ok = 1; break; end
    end
    @(negedge clk); s_tvalid = '0;
    total++; if (ok == 0) begin bad++; $display("FAIL rr_wait: got %0d grants want 5", gnt_q.size()); end
    for (int k = 0; k < 5; k++) begin
      total++;
      if (gnt_q.size() <= k || gnt_q[k] != k % NR) begin bad++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, (gnt_q.size() > k) ? gnt_q[k] : -1, k % NR); end
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (done_q.size() <= k || done_q[k] != k) begin bad++; $display("FAIL rr_done[%0d]: got %0d want %0d", k, (done_q.size() > k) ? done_q[k] : -1, k); end
    end
    for (int k = 1; k < 5; k++) begin
      total++;
      if (gap_q.size() <= k || gap_q[k] < GAP) begin bad++; $display("FAIL rr_gap[%0d]: got %0d want >=%0d", k, (gap_q.size() > k) ? gap_q[k] : -1, GAP); end
    end
    total++; if (viol_cnt != 0) begin bad++; $display("FAIL rr_invariants: got %0d violations want 0", viol_cnt); end
    repeat (40) @(negedge clk);
  endtask

  task automatic test_drop();
    do_reset(); eng_len = 3; m_tready = 1'b0;
    @(negedge clk); s_tvalid = 4'b0100; s_tdata[2*DW +: DW] = 16'h2222;
    @(negedge clk); #1;
    total++; if (grant !== 4'b0100 || m_tvalid !== 1'b1) begin bad++; $display("FAIL drop_grant: got %b v=%b want 0100 v=1", grant, m_tvalid); end
    @(negedge clk); s_tvalid = '0; #1;
    total++; if (m_tvalid !== 1'b0 || s_tready !== 4'b0000) begin bad++; $display("FAIL drop_send: got v=%b rdy=%b want 0/0000", m_tvalid, s_tready); end
    @(negedge clk); s_tvalid = 4'b1100; s_tdata[3*DW +: DW] = 16'h3333; m_tready = 1'b1; #1;
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL drop_release: got %b want 0000", grant); end
    @(negedge clk); #1;
    total++; if (grant !== 4'b0100 || m_tdata !== 16'h2222) begin bad++; $display("FAIL drop_ptr: got %b d=%h want 0100 d=2222", grant, m_tdata); end
    @(negedge clk); s_tvalid = '0;
    repeat (40) @(negedge clk);
    total++; if (hs_req_q.size() != 1 || hs_req_q[0] != 2) begin bad++; $display("FAIL drop_beats: got n=%0d want one beat from 2", hs_req_q.size()); end
  endtask

  task automatic test_reset_mid();
    int ok;
    do_reset(); eng_len = 3;
    @(negedge clk); s_tvalid = 4'b0001; s_tdata[0 +: DW] = 16'h0A0A;
    ok = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk); #3;
      if (hs_req_q.size() > 0) begin ok = 1; break; end
    end
    @(negedge clk); s_tvalid = '0;
    repeat (30) @(negedge clk);
    eng_auto = 1'b0; man_busy = 1'b0;
    s_tvalid = 4'b0010; s_tdata[1*DW +: DW] = 16'h1111;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk); #1;
      if (m_tvalid && m_tready) begin ok = ok + 1; break; end
    end
    total++; if (ok != 2) begin bad++; $display("FAIL mid_setup: got %0d handshakes want 2", ok); end
    @(negedge clk); s_tvalid = '0; man_busy = 1'b1;
    repeat (3) @(negedge clk);
    arstn = 1'b0; #1;
    total++; if (done !== 4'b0000) begin bad++; $display("FAIL mid_rst_done: got %b want 0000", done); end
    @(negedge clk); arstn = 1'b1; man_busy = 1'b0; #1;
    total++; if (grant !== 4'b0000 || m_tvalid !== 1'b0 || done !== 4'b0000) begin bad++; $display("FAIL mid_rst_state: got g=%b v=%b d=%b want 0000/0/0000", grant, m_tvalid, done); end
    @(negedge clk); eng_auto = 1'b1; s_tvalid = 4'b0011; s_tdata[0 +: DW] = 16'h0B0B;
    @(negedge clk); #1;
    total++; if (grant !== 4'b0001) begin bad++; $display("FAIL mid_restart: got %b want 0001", grant); end
    @(negedge clk); s_tvalid = '0;
    repeat (40) @(negedge clk);
    total++; if (done_q.size() != 2 || done_q[1] != 0) begin bad++; $display("FAIL mid_done_count: got %0d dones want 2 (0,0)", done_q.size()); end
  endtask

  task automatic test_random();
    logic [DW-1:0] src [NR][$];
    logic [DW-1:0] mdl [NR][$];
    int exp_req[$];
    logic [DW-1:0] exp_dat[$];
    int ptr, found, n, c, stalled;
    logic all_empty;
    for (int r = 0; r < 3; r++) begin
      do_reset(); eng_len = $urandom_range(1, 6);
      for (int i = 0; i < NR; i++) begin
        src[i].delete();
        n = $urandom_range(0, 3);
        if (i == r && n == 0) n = 1;
        for (int j = 0; j < n; j++) src[i].push_back(DW'($urandom));
        mdl[i] = src[i];
      end
      // Reference: serve in rotation from the requester after the last one served
      exp_req.delete(); exp_dat.delete(); ptr = NR - 1;
      forever begin
        found = -1;
        for (int k = 1; k <= NR; k++) begin
          c = (ptr + k) % NR;
          if (found < 0 && mdl[c].size() > 0) found = c;
        end
        if (found < 0) break;
        exp_req.push_back(found);
        exp_dat.push_back(mdl[found].pop_front());
        ptr = found;
      end
      stalled = 1;
      for (int t = 0; t < 3000; t++) begin
        @(negedge clk);
        for (int i = 0; i < NR; i++) begin
          s_tvalid[i] = (src[i].size() > 0);
          if (src[i].size() > 0) s_tdata[i*DW +: DW] = src[i][0];
        end
        m_tready = ($urandom_range(0, 2) != 0);
        #1;
        all_empty = 1'b1;
        for (int i = 0; i < NR; i++) begin
          if (s_tvalid[i] && s_tready[i]) void'(src[i].pop_front());
          if (src[i].size() > 0) all_empty = 1'b0;
        end
        if (all_empty) begin stalled = 0; break; end
      end
      @(negedge clk); s_tvalid = '0; m_tready = 1'b1;
      repeat (40) @(negedge clk);
      total++; if (stalled != 0) begin bad++; $display("FAIL rand_progress[%0d]: sources not drained", r); end
      total++; if (hs_req_q.size() != exp_req.size() || m_dat_q.size() != exp_req.size()) begin bad++; $display("FAIL rand_count[%0d]: got %0d/%0d want %0d", r, hs_req_q.size(), m_dat_q.size(), exp_req.size()); end
      foreach (exp_req[k]) begin
        total++;
        if (hs_req_q.size() <= k || hs_req_q[k] != exp_req[k] || hs_dat_q[k] !== exp_dat[k] || m_dat_q[k] !== exp_dat[k])
          begin bad++; $display("FAIL rand_beat[%0d.%0d]: got req=%0d d=%h want req=%0d d=%h", r, k, (hs_req_q.size() > k) ? hs_req_q[k] : -1, (m_dat_q.size() > k) ? m_dat_q[k] : 16'h0, exp_req[k], exp_dat[k]); end
        total++;
        if (done_q.size() <= k || done_q[k] != exp_req[k]) begin bad++; $display("FAIL rand_done[%0d.%0d]: got %0d want %0d", r, k, (done_q.size() > k) ? done_q[k] : -1, exp_req[k]); end
      end
      total++; if (viol_cnt != 0 || tmo_n != 0) begin bad++; $display("FAIL rand_invariants[%0d]: got viol=%0d tmo=%0d want 0/0", r, viol_cnt, tmo_n); end
    end
  endtask

`ifdef I2C_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int tc;
    do_reset(); eng_auto = 1'b0; man_busy = 1'b0;
    @(negedge clk); s_tvalid = 4'b0100; s_tdata[2*DW +: DW] = 16'h7777;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk); #1;
      if (m_tvalid && m_tready) break;
    end
    @(negedge clk); s_tvalid = '0;
    tc = -1;
    for (int t = 1; t <= 30; t++) begin
      #1;
      if (timeout === 1'b1) begin tc = t; break; end
      @(negedge clk);
    end
    total++; if (tc != TMO) begin bad++; $display("FAIL tmo_cycle: got %0d want %0d", tc, TMO); end
    @(negedge clk); #1;
    total++; if (grant !== 4'b0000 || done_q.size() != 0) begin bad++; $display("FAIL tmo_release: got g=%b dones=%0d want 0000/0", grant, done_q.size()); end
    eng_auto = 1'b1;
  endtask
`endif

  initial begin
    arstn = 1'b0; s_tvalid = '0; s_tdata = '0; m_tready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_drop();
    test_reset_mid();
    test_random();
`ifdef I2C_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
